// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and the renderer colour-field layout.
// Imported by the timing generator; totals are derived rather than hard-coded.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL =
      VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL =
      VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned COL_R_HI = 7;
  localparam int unsigned COL_R_LO = 5;
  localparam int unsigned COL_G_HI = 4;
  localparam int unsigned COL_G_LO = 2;
  localparam int unsigned COL_B_HI = 1;
  localparam int unsigned COL_B_LO = 0;

  typedef struct packed {
    logic [COL_R_HI-COL_R_LO:0] r;
    logic [COL_G_HI-COL_G_LO:0] g;
    logic [COL_B_HI-COL_B_LO:0] b;
  } colour_t;

  localparam colour_t COLOUR_BLANK = '0;

  // Half-open window test used for the sync pulses: lo <= pos < hi.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Free-running system-clock divider producing a one-cycle pixel enable.
// TICK is high in the cycle where the divider sits at CLK_DIV-1 (CLK_DIV >= 2).
module pixel_clk_en #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign TICK = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, registered pixel address, and colour/sync outputs
// aligned one pixel behind the address so the renderer's reply lines up with HS/VS.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COLOUR_IN,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic       FRAME_TICK
);

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned H_TOTAL      = H_SYNC_END + H_BP;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned V_TOTAL      = V_SYNC_END + V_BP;

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic       w_tick;
  logic       w_line_end;
  logic       w_frame_end;
  logic       w_visible;
  logic [9:0] w_hcount_nxt;
  logic [9:0] w_vcount_nxt;
  logic [9:0] w_addrh_nxt;
  logic [8:0] w_addrv_nxt;
  colour_t    w_colour_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;

  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic [9:0] r_addrh;
  logic [8:0] r_addrv;
  colour_t    r_colour;
  logic       r_hs;
  logic       r_vs;
  logic       r_frame_tick;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (w_tick)
  );

  always_comb begin
    w_line_end   = (r_hcount == H_LAST);
    w_frame_end  = w_line_end && (r_vcount == V_LAST);
    w_hcount_nxt = w_line_end ? 10'd0 : r_hcount + 10'd1;
    w_vcount_nxt = r_vcount;
    if (w_line_end) begin
      w_vcount_nxt = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
    end
    // Addresses track the post-advance counters; everything else uses pre-advance.
    w_addrh_nxt  = (w_hcount_nxt < H_VIS) ? w_hcount_nxt : 10'd0;
    w_addrv_nxt  = (w_vcount_nxt < V_VIS) ? w_vcount_nxt[8:0] : 9'd0;
    w_visible    = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    w_colour_nxt = w_visible ? colour_t'(COLOUR_IN) : COLOUR_BLANK;
    w_hs_nxt     = !in_span(r_hcount, H_SS, H_SE);
    w_vs_nxt     = !in_span(r_vcount, V_SS, V_SE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_addrh      <= '0;
      r_addrv      <= '0;
      r_colour     <= COLOUR_BLANK;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_tick) begin
        r_hcount     <= w_hcount_nxt;
        r_vcount     <= w_vcount_nxt;
        r_addrh      <= w_addrh_nxt;
        r_addrv      <= w_addrv_nxt;
        r_colour     <= w_colour_nxt;
        r_hs         <= w_hs_nxt;
        r_vs         <= w_vs_nxt;
        r_frame_tick <= w_frame_end;
      end
    end
  end

  assign ADDRH      = r_addrh;
  assign ADDRV      = r_addrv;
  assign COLOUR_OUT = r_colour;
  assign HS         = r_hs;
  assign VS         = r_vs;
  assign FRAME_TICK = r_frame_tick;

endmodule
